aes_key_sched_iter: RTL



---
 rtl/aes_key_sched_iter_if.sv | 29 ++
 rtl/aes_key_sched_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_key_sched_iter_if : handshake, key and round-key readback bus   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface aes_key_sched_iter_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_err;

  modport master (
    output start, key_len, key, rd_idx,
    input  busy, done, err, keys_valid, num_rounds, rd_key, rd_err
  );

  modport slave (
    input  start, key_len, key, rd_idx,
    output busy, done, err, keys_valid, num_rounds, rd_key, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_sched_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_key_sched_iter : iterative AES-128/192/256 key schedule, one    |
// | word per clock, with a buffered round-key read port. rev 1.0        |
// +--------------------------------------------------------------------+
module sBox_8 (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so byte a lives at bits [8*(255-a)+7 -: 8].
  assign sub_val = C_SBOX[{~byte_val, 3'b111} -: 8];
endmodule

module aes_key_sched_iter #(
  parameter int MAX_NK = 8
) (
  input logic           clk,
  input logic           rst,
  aes_key_sched_iter_if.slave bus
);
  localparam int         WIN_AW   = $clog2(MAX_NK);
  localparam logic [3:0] C_MAX_NK = 4'(MAX_NK);

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_LOAD   = 2'd1;
  localparam logic [1:0] C_ST_EXPAND = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_nk;
  logic [WIN_AW-1:0] r_old_sel;
  logic [2:0]        r_j_last;
  logic [255:0]      r_key;
  logic [5:0]        r_i;
  logic [5:0]        r_last;
  logic [2:0]        r_j;
  logic [7:0]        r_rcon;
  logic [31:0]       r_win [MAX_NK];
  logic [31:0]       r_buf [60];
  logic              r_done;
  logic              r_err;
  logic              r_valid;
  logic [3:0]        r_nr;
  logic [127:0]      r_rd_key;
  logic              r_rd_err;

  logic [3:0]  w_nk;
  logic        w_len_ok;
  logic        w_accept;
  logic        w_busy;
  logic [31:0] w_temp;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_old;
  logic [31:0] w_mix;
  logic [31:0] w_new;
  logic [3:0]  w_rd_row;
  logic [5:0]  w_rd_base;

  always_comb begin
    w_nk     = 4'd4;
    w_len_ok = 1'b1;
    case (bus.key_len)
      2'b00:   w_nk = 4'd4;
      2'b01:   w_nk = 4'd6;
      2'b10:   w_nk = 4'd8;
      default: w_len_ok = 1'b0;
    endcase
  end

  assign w_busy   = (r_state != C_ST_IDLE);
  assign w_accept = (r_state == C_ST_IDLE) && bus.start && w_len_ok && (w_nk <= C_MAX_NK);

  // Window slot 0 holds w[i-1]; slot Nk-1 holds w[i-Nk].
  assign w_temp   = r_win[0];
  assign w_old    = r_win[r_old_sel];
  assign w_sub_in = (r_j == 3'd0) ? {w_temp[23:0], w_temp[31:24]} : w_temp;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sBox_8 u_sbox (
      .byte_val (w_sub_in[8*b +: 8]),
      .sub_val  (w_sub_out[8*b +: 8])
    );
  end

  always_comb begin
    w_mix = w_temp;
    if (r_j == 3'd0)
      w_mix = w_sub_out ^ {r_rcon, 24'h0};
    else if (r_nk == 4'd8 && r_j == 3'd4)
      w_mix = w_sub_out;
  end

  assign w_new = (r_state == C_ST_LOAD) ? r_key[255:224] : (w_old ^ w_mix);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_nr    <= 4'd10;
      r_nk    <= 4'd4;
      r_i     <= 6'd0;
      r_j     <= 3'd0;
      r_rcon  <= 8'h01;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (w_accept) begin
            r_state   <= C_ST_LOAD;
            r_nk      <= w_nk;
            r_old_sel <= WIN_AW'(w_nk - 4'd1);
            r_j_last  <= 3'(w_nk - 4'd1);
            r_last    <= {w_nk, 2'b00} + 6'd27;
            r_nr      <= w_nk + 4'd6;
            r_key     <= bus.key;
            r_valid   <= 1'b0;
            r_i       <= 6'd0;
            r_j       <= 3'd0;
            r_rcon    <= 8'h01;
          end else if (bus.start) begin
            r_err <= 1'b1;
          end
        end
        C_ST_LOAD, C_ST_EXPAND: begin
          r_i <= r_i + 6'd1;
          r_j <= (r_j == r_j_last) ? 3'd0 : r_j + 3'd1;
          if (r_state == C_ST_LOAD) begin
            r_key <= r_key << 32;
            if (r_j == r_j_last)
              r_state <= C_ST_EXPAND;
          end else begin
            if (r_j == 3'd0)
              r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            if (r_i == r_last) begin
              r_state <= C_ST_IDLE;
              r_done  <= 1'b1;
              r_valid <= 1'b1;
            end
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  // The buffer and window survive reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_busy) begin
      r_buf[r_i] <= w_new;
      for (int k = MAX_NK - 1; k > 0; k--)
        r_win[k] <= r_win[k-1];
      r_win[0] <= w_new;
    end
  end

  assign w_rd_row  = (bus.rd_idx > 4'd14) ? 4'd14 : bus.rd_idx;
  assign w_rd_base = {w_rd_row, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_key <= 128'h0;
      r_rd_err <= 1'b0;
    end else if (bus.rd_idx > r_nr) begin
      r_rd_key <= 128'h0;
      r_rd_err <= 1'b1;
    end else begin
      r_rd_key <= {r_buf[w_rd_base], r_buf[w_rd_base + 6'd1],
                   r_buf[w_rd_base + 6'd2], r_buf[w_rd_base + 6'd3]};
      r_rd_err <= 1'b0;
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.keys_valid = r_valid;
  assign bus.num_rounds = r_nr;
  assign bus.rd_key     = r_rd_key;
  assign bus.rd_err     = r_rd_err;
endmodule
`default_nettype wire
